// File: rtl/morse_pkg.sv
// Shared constants for the timed Morse receiver: letter codes, symbol values, FSM states.
package morse_pkg;

   localparam logic [5:0] L_UNKNOWN = 6'd0;
   localparam logic [5:0] L_A = 6'd1,  L_B = 6'd2,  L_C = 6'd3,  L_D = 6'd4,  L_E = 6'd5;
   localparam logic [5:0] L_F = 6'd6,  L_G = 6'd7,  L_H = 6'd8,  L_I = 6'd9,  L_J = 6'd10;
   localparam logic [5:0] L_K = 6'd11, L_L = 6'd12, L_M = 6'd13, L_N = 6'd14, L_O = 6'd15;
   localparam logic [5:0] L_P = 6'd16, L_Q = 6'd17, L_R = 6'd18, L_S = 6'd19, L_T = 6'd20;
   localparam logic [5:0] L_U = 6'd21, L_V = 6'd22, L_W = 6'd23, L_X = 6'd24, L_Y = 6'd25;
   localparam logic [5:0] L_Z = 6'd26;
   localparam logic [5:0] L_N0 = 6'd27, L_N1 = 6'd28, L_N2 = 6'd29, L_N3 = 6'd30, L_N4 = 6'd31;
   localparam logic [5:0] L_N5 = 6'd32, L_N6 = 6'd33, L_N7 = 6'd34, L_N8 = 6'd35, L_N9 = 6'd36;
   localparam logic [5:0] L_SPACE = 6'd37;

   localparam logic SYM_DIT = 1'b0;
   localparam logic SYM_DAH = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MARK,
      ST_SPACE,
      ST_GAP
   } rx_state_e;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse table: (length, pattern) -> letter code. First symbol sits in the MSB
// of the used bits; dah=1, dit=0.
module morse_lut
   import morse_pkg::*;
(
   input  logic [3:0] len_i,
   input  logic [4:0] pat_i,
   output logic [5:0] code_o
);

   always_comb begin
      code_o = L_UNKNOWN;
      case ({len_i, pat_i})
         {4'd1, 5'b00000}: code_o = L_E;
         {4'd1, 5'b00001}: code_o = L_T;
         {4'd2, 5'b00000}: code_o = L_I;
         {4'd2, 5'b00001}: code_o = L_A;
         {4'd2, 5'b00010}: code_o = L_N;
         {4'd2, 5'b00011}: code_o = L_M;
         {4'd3, 5'b00000}: code_o = L_S;
         {4'd3, 5'b00001}: code_o = L_U;
         {4'd3, 5'b00010}: code_o = L_R;
         {4'd3, 5'b00011}: code_o = L_W;
         {4'd3, 5'b00100}: code_o = L_D;
         {4'd3, 5'b00101}: code_o = L_K;
         {4'd3, 5'b00110}: code_o = L_G;
         {4'd3, 5'b00111}: code_o = L_O;
         {4'd4, 5'b00000}: code_o = L_H;
         {4'd4, 5'b00001}: code_o = L_V;
         {4'd4, 5'b00010}: code_o = L_F;
         {4'd4, 5'b00100}: code_o = L_L;
         {4'd4, 5'b00110}: code_o = L_P;
         {4'd4, 5'b00111}: code_o = L_J;
         {4'd4, 5'b01000}: code_o = L_B;
         {4'd4, 5'b01001}: code_o = L_X;
         {4'd4, 5'b01010}: code_o = L_C;
         {4'd4, 5'b01011}: code_o = L_Y;
         {4'd4, 5'b01100}: code_o = L_Z;
         {4'd4, 5'b01101}: code_o = L_Q;
         {4'd5, 5'b11111}: code_o = L_N0;
         {4'd5, 5'b01111}: code_o = L_N1;
         {4'd5, 5'b00111}: code_o = L_N2;
         {4'd5, 5'b00011}: code_o = L_N3;
         {4'd5, 5'b00001}: code_o = L_N4;
         {4'd5, 5'b00000}: code_o = L_N5;
         {4'd5, 5'b10000}: code_o = L_N6;
         {4'd5, 5'b11000}: code_o = L_N7;
         {4'd5, 5'b11100}: code_o = L_N8;
         {4'd5, 5'b11110}: code_o = L_N9;
         default:          code_o = L_UNKNOWN;
      endcase
   end

endmodule

// File: rtl/morse_rx_timed.sv
// Timed Morse receiver: measures key mark/space durations, decodes letters into an output FIFO.
// Define MORSE_RX_GLITCH_FILTER_EN to insert a DEBOUNCE-sample glitch filter after the synchroniser.
module morse_rx_timed
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 8,
   parameter int MAX_SYMBOLS = 5,
   parameter int FIFO_DEPTH  = 4,
   parameter int DEBOUNCE    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_in,
   output logic [5:0] letter,
   output logic       letter_valid,
   input  logic       letter_ready,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(7 * UNIT_CYCLES + 1);
   localparam int LW = $clog2(MAX_SYMBOLS + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DAH_TH   = CW'(2 * UNIT_CYCLES);
   localparam logic [CW-1:0] LTR_TH   = CW'(3 * UNIT_CYCLES);
   localparam logic [CW-1:0] WRD_TH   = CW'(7 * UNIT_CYCLES);
   localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_SYMBOLS);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   logic sync1_q, sync2_q, key_s, key_prev_q;

   // NOTE: non-blocking assignments make sync2_q take last cycle's sync1_q, giving two real flop stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= key_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef MORSE_RX_GLITCH_FILTER_EN
   localparam int DW = $clog2(DEBOUNCE + 1);
   logic          filt_q;
   logic [DW-1:0] db_q;

   // The filtered level follows only after DEBOUNCE consecutive samples disagree with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= 1'b0;
         db_q   <= '0;
      end else if (sync2_q == filt_q) begin
         db_q <= '0;
      end else if (db_q == DW'(DEBOUNCE - 1)) begin
         filt_q <= sync2_q;
         db_q   <= '0;
      end else begin
         db_q <= db_q + 1'b1;
      end
   end
   assign key_s = filt_q;
`else
   assign key_s = sync2_q;
`endif

   logic          key_edge;
   logic [CW-1:0] cnt_q;

   assign key_edge = key_s ^ key_prev_q;

   // On the edge cycle cnt_q still holds the length of the level that just ended.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_prev_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         key_prev_q <= key_s;
         if (key_edge)             cnt_q <= CW'(1);
         else if (cnt_q != WRD_TH) cnt_q <= cnt_q + 1'b1;
      end
   end

   rx_state_e        state_q, state_d;
   logic             append, clear, push;
   logic [5:0]       push_code;
   logic [MAX_SYMBOLS-1:0] pat_q;
   logic [LW-1:0]    len_q;
   logic             sym_ovf_q;
   logic [3:0]       lut_len;
   logic [4:0]       lut_pat;
   logic [5:0]       lut_code;

   assign lut_len = (int'(len_q) > 5) ? 4'd0 : 4'(len_q);
   assign lut_pat = 5'(pat_q);

   morse_lut u_lut (
      .len_i  (lut_len),
      .pat_i  (lut_pat),
      .code_o (lut_code)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      append    = 1'b0;
      clear     = 1'b0;
      push      = 1'b0;
      push_code = L_UNKNOWN;
      case (state_q)
         ST_IDLE: if (key_s) state_d = ST_MARK;
         ST_MARK: begin
            if (!key_s) begin
               append  = 1'b1;
               state_d = ST_SPACE;
            end
         end
         ST_SPACE: begin
            if (cnt_q == LTR_TH) begin
               push      = 1'b1;
               push_code = sym_ovf_q ? L_UNKNOWN : lut_code;
               clear     = 1'b1;
               state_d   = key_s ? ST_MARK : ST_GAP;
            end else if (key_s) begin
               state_d = ST_MARK;
            end
         end
         ST_GAP: begin
            if (cnt_q == WRD_TH) begin
               push      = 1'b1;
               push_code = L_SPACE;
               state_d   = key_s ? ST_MARK : ST_IDLE;
            end else if (key_s) begin
               state_d = ST_MARK;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_q     <= '0;
         len_q     <= '0;
         sym_ovf_q <= 1'b0;
      end else if (clear) begin
         pat_q     <= '0;
         len_q     <= '0;
         sym_ovf_q <= 1'b0;
      end else if (append) begin
         if (len_q == LEN_MAX) begin
            sym_ovf_q <= 1'b1;
         end else begin
            pat_q <= {pat_q[MAX_SYMBOLS-2:0], (cnt_q >= DAH_TH) ? SYM_DAH : SYM_DIT};
            len_q <= len_q + 1'b1;
         end
      end
   end

   logic [5:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   fcnt_q;
   logic          overrun_q, full, pop, push_ok;

   assign full    = (fcnt_q == FULL_CNT);
   assign pop     = letter_valid && letter_ready;
   assign push_ok = push && (!full || pop);

   // NOTE: the storage array has no reset; the output mux below hides it until it is written.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_code;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fcnt_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   fcnt_q <= fcnt_q + 1'b1;
            2'b01:   fcnt_q <= fcnt_q - 1'b1;
            default: ;
         endcase
         if (push && !push_ok) overrun_q <= 1'b1;
      end
   end

   assign letter_valid = (fcnt_q != '0);
   assign letter       = letter_valid ? mem_q[rd_ptr_q] : L_UNKNOWN;
   assign overrun      = overrun_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_rx_timed.sv
// Self-checking bench for morse_rx_timed: duration-level Morse model, randomized keying, FIFO checks.
// Compile with MORSE_RX_GLITCH_FILTER_EN to also exercise the glitch filter.
module tb_morse_rx_timed;

   localparam int U     = 4;
   localparam int DEPTH = 4;
   localparam int DEB   = 3;
`ifdef MORSE_RX_GLITCH_FILTER_EN
   localparam int LAT  = DEB;
   localparam int MINP = DEB;
`else
   localparam int LAT  = 0;
   localparam int MINP = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       key_in;
   logic       letter_ready;
   logic [5:0] letter;
   logic       letter_valid, overrun, busy;

   always #5 clk = ~clk;

   morse_rx_timed #(
      .UNIT_CYCLES (U),
      .MAX_SYMBOLS (5),
      .FIFO_DEPTH  (DEPTH),
      .DEBOUNCE    (DEB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .key_in       (key_in),
      .letter       (letter),
      .letter_valid (letter_valid),
      .letter_ready (letter_ready),
      .overrun      (overrun),
      .busy         (busy)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Code-indexed Morse table written as dots and dashes.
   string morse_tab [37] = '{"",
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
      "..-", "...-", ".--", "-..-", "-.--", "--..",
      "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};

   // Behavioural model: symbols accumulate as text; gaps decide letter/word boundaries.
   string cur_sym = "";
   int    exp_q[$];
   bit    hold_mode = 1'b0;
   bit    exp_overrun = 1'b0;
   bit    rand_ready = 1'b0;
   bit    ready_force = 1'b1;

   function automatic int model_decode(input string s);
      if (s.len() == 0 || s.len() > 5) return 0;
      for (int c = 1; c <= 36; c++)
         if (morse_tab[c] == s) return c;
      return 0;
   endfunction

   function automatic void model_push(input int c);
      if (hold_mode && exp_q.size() >= DEPTH) exp_overrun = 1'b1;
      else exp_q.push_back(c);
   endfunction

   function automatic void model_ms(input int mark, input int space);
      if (mark >= 2 * U) cur_sym = {cur_sym, "-"};
      else               cur_sym = {cur_sym, "."};
      if (space >= 3 * U) begin
         model_push(model_decode(cur_sym));
         cur_sym = "";
         if (space >= 7 * U) model_push(37);
      end
   endfunction

   task automatic send(input int mark, input int space);
      model_ms(mark, space);
      key_in = 1'b1;
      repeat (mark) @(negedge clk);
      key_in = 1'b0;
      repeat (space) @(negedge clk);
   endtask

   task automatic send_pattern(input string p, input int space_after);
      for (int i = 0; i < p.len(); i++) begin
         int mark, sp;
         if (p.getc(i) == "-") mark = $urandom_range(3 * U + 3, 2 * U);
         else                  mark = $urandom_range(2 * U - 1, MINP);
         sp = (i == p.len() - 1) ? space_after : $urandom_range(3 * U - 1, MINP);
         send(mark, sp);
      end
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      #1;
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      letter_ready = 1'b1;
      forever begin
         @(negedge clk);
         letter_ready = rand_ready ? ($urandom_range(3, 0) != 0) : ready_force;
      end
   end

   // Compare process: every accepted letter against the model queue, and hold stability.
   bit         prev_hold = 1'b0;
   logic [5:0] prev_letter = '0;
   always @(negedge clk) begin
      #1;
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", letter_valid, 1);
            check("hold_letter", letter, prev_letter);
         end
         if (letter_valid && letter_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected: got letter %0d, model expected nothing", letter);
            end else begin
               check("pop_letter", letter, exp_q.pop_front());
            end
         end
         prev_hold   = letter_valid && !letter_ready;
         prev_letter = letter;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b1;
      key_in = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_letter", letter, 0);
      check("rst_valid", letter_valid, 0);
      check("rst_overrun", overrun, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;

      check("model_E", model_decode("."), 5);
      check("model_A", model_decode(".-"), 1);
      check("model_0", model_decode("-----"), 27);
      check("model_9", model_decode("----."), 36);
      check("model_6dit", model_decode("......"), 0);
      check("model_bad4", model_decode("..--"), 0);

      // E: exact push latency of letter and word space.
      repeat (2) @(negedge clk);
      model_ms(4, 40);
      key_in = 1'b1;
      repeat (4) @(negedge clk);
      key_in = 1'b0;
      for (int m = 1; m <= 40; m++) begin
         @(negedge clk);
         #1;
         if (m == 14 + LAT) check("E_valid_early", letter_valid, 0);
         if (m == 15 + LAT) begin
            check("E_valid_rise", letter_valid, 1);
            check("E_code", letter, 5);
         end
         if (m == 22 + LAT) check("E_no_extra", letter_valid, 0);
         if (m == 30 + LAT) check("wsp_valid_early", letter_valid, 0);
         if (m == 31 + LAT) begin
            check("wsp_valid_rise", letter_valid, 1);
            check("wsp_code", letter, 37);
         end
      end
      wait_drain("E_drain");

      // A then word space, then long silence emits nothing.
      send(4, 4);
      send(12, 28);
      repeat (100) @(negedge clk);
      #1;
      check("A_idle_busy", busy, 0);
      check("A_drain", exp_q.size(), 0);

      // Five dahs with exactly 3U after; next letter starts on the threshold cycle.
      for (int i = 0; i < 4; i++) send(12, 4);
      send(12, 12);
      for (int i = 0; i < 5; i++) send(4, 4);
      send(4, 40);
      wait_drain("zero_ovf_drain");

      // FIFO full with ready low: first four kept, rest dropped, overrun sticky.
      hold_mode   = 1'b1;
      ready_force = 1'b0;
      for (int c = 1; c <= 5; c++) send_pattern(morse_tab[c], (c == 5) ? 40 : 16);
      repeat (5) @(negedge clk);
      #1;
      check("ovr_set", overrun, 1);
      check("ovr_model", overrun, exp_overrun);
      check("ovr_head", letter, 1);
      check("ovr_valid", letter_valid, 1);
      hold_mode   = 1'b0;
      ready_force = 1'b1;
      wait_drain("ovr_drain");
      check("ovr_sticky", overrun, 1);

      // Reset mid-mark of a 2-symbol letter with a pending code in the FIFO.
      ready_force = 1'b0;
      send(4, 16);
      send(4, 4);
      key_in = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("prerst_valid", letter_valid, 1);
      check("prerst_letter", letter, 5);
      check("prerst_busy", busy, 1);
      #1;
      rst    = 1'b1;
      key_in = 1'b0;
      exp_q.delete();
      cur_sym     = "";
      exp_overrun = 1'b0;
      #1;
      check("midrst_valid", letter_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_overrun", overrun, 0);
      check("midrst_letter", letter, 0);
      repeat (2) @(negedge clk);
      rst         = 1'b0;
      ready_force = 1'b1;
      send(12, 30);
      wait_drain("T_drain");

`ifdef MORSE_RX_GLITCH_FILTER_EN
      // Short pulse inside a space is invisible: still one E then a word space.
      model_ms(4, 42);
      key_in = 1'b1;
      repeat (4) @(negedge clk);
      key_in = 1'b0;
      repeat (5) @(negedge clk);
      key_in = 1'b1;
      repeat (2) @(negedge clk);
      key_in = 1'b0;
      repeat (35) @(negedge clk);
      wait_drain("glitch_space_drain");
      key_in = 1'b1;
      repeat (2) @(negedge clk);
      key_in = 1'b0;
      for (int m = 0; m < 12; m++) begin
         @(negedge clk);
         #1;
         if (m % 4 == 0) check("glitch_idle_busy", busy, 0);
      end
      check("glitch_idle_valid", letter_valid, 0);
`endif

      // Randomized letters, junk overlong letters, boundary gaps, random consumer.
      rand_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         int    sel, sp;
         string p;
         sel = $urandom_range(7, 0);
         if (sel == 0) p = ($urandom_range(1, 0) != 0) ? "......" : "-.-.-.";
         else          p = morse_tab[$urandom_range(36, 1)];
         case ($urandom_range(5, 0))
            0:       sp = 3 * U;
            1:       sp = 7 * U - 1;
            2:       sp = 7 * U;
            3:       sp = $urandom_range(9 * U, 7 * U);
            default: sp = $urandom_range(7 * U - 1, 3 * U);
         endcase
         if (n == 39) sp = 40;
         send_pattern(p, sp);
      end
      rand_ready  = 1'b0;
      ready_force = 1'b1;
      wait_drain("rand_drain");
      repeat (10) @(negedge clk);
      #1;
      check("rand_end_busy", busy, 0);
      check("rand_end_overrun", overrun, 0);
      check("rand_end_valid", letter_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
